// File: rtl/display_decoder.sv
// Readback decoder: six active-low 7-segment digits (MSD first) -> 20-bit binary, one digit per clock.
// Latency 7 cycles start->done (k+2 on an invalid digit at index k); one decode per 8 cycles.
// No backpressure: start is ignored unless idle. Optional DISPLAY_DECODER_BLANK_EN accepts leading blanks.
module display_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  displayBits [0:5],
    output logic        busy,
    output logic        done,
    output logic [19:0] result,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  shadow [0:5];
    logic [2:0]  idx;
    logic [19:0] acc, acc_nxt;
    logic        err_flag;
    logic [7:0]  cur_pat;
    logic [3:0]  dig;
    logic        dig_vld;
`ifdef DISPLAY_DECODER_BLANK_EN
    logic        seen;
`endif

    // Digit recognition; dp is forced off so it never affects the match.
    always_comb begin
        cur_pat = 8'hFF;
        case (idx)
            3'd0:    cur_pat = shadow[0];
            3'd1:    cur_pat = shadow[1];
            3'd2:    cur_pat = shadow[2];
            3'd3:    cur_pat = shadow[3];
            3'd4:    cur_pat = shadow[4];
            3'd5:    cur_pat = shadow[5];
            default: cur_pat = 8'hFF;
        endcase
        dig     = 4'd0;
        dig_vld = 1'b1;
        case (cur_pat | 8'h80)
            8'hC0:   dig = 4'd0;
            8'hF9:   dig = 4'd1;
            8'hA4:   dig = 4'd2;
            8'hB0:   dig = 4'd3;
            8'h99:   dig = 4'd4;
            8'h92:   dig = 4'd5;
            8'h82:   dig = 4'd6;
            8'hF8:   dig = 4'd7;
            8'h80:   dig = 4'd8;
            8'h90:   dig = 4'd9;
`ifdef DISPLAY_DECODER_BLANK_EN
            8'hFF:   dig_vld = ~seen;
`endif
            default: dig_vld = 1'b0;
        endcase
        acc_nxt = (acc << 3) + (acc << 1) + {16'd0, dig};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DECODE;
            DECODE:  if (!dig_vld || idx == 3'd5) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            acc      <= 20'd0;
            err_flag <= 1'b0;
            done     <= 1'b0;
            result   <= 20'd0;
            error    <= 1'b0;
            for (int i = 0; i < 6; i++) shadow[i] <= 8'hFF;
`ifdef DISPLAY_DECODER_BLANK_EN
            seen     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow   <= displayBits;
                        acc      <= 20'd0;
                        idx      <= 3'd0;
                        err_flag <= 1'b0;
`ifdef DISPLAY_DECODER_BLANK_EN
                        seen     <= 1'b0;
`endif
                    end
                end
                DECODE: begin
                    acc <= acc_nxt;
                    if (!dig_vld) err_flag <= 1'b1;
                    else if (idx != 3'd5) idx <= idx + 3'd1;
`ifdef DISPLAY_DECODER_BLANK_EN
                    // A blank only counts as leading until the first real digit.
                    if ((cur_pat | 8'h80) != 8'hFF) seen <= 1'b1;
`endif
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= err_flag ? 20'd0 : acc;
                    error  <= err_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
